// File: rtl/ldst_mem_resp.sv
// Data-memory responder for the ldst unit: owns the data RAM, serves the core port
// with absolute priority and a host load/dump port through a req/gnt handshake.
module ldst_mem_resp #(
    parameter int unsigned DAT_W      = 32,
    parameter int unsigned D_ADDR_W   = 10,
    parameter int unsigned RD_LAT     = 1,
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                dat_mem_en_b,
    input  logic                dat_mem_rw,
    input  logic [D_ADDR_W-1:0] dat_mem_addr,
    input  logic [DAT_W-1:0]    o_mem_dat,
    output logic [DAT_W-1:0]    i_mem_dat,
    input  logic                hst_req,
    input  logic                hst_we,
    input  logic [D_ADDR_W-1:0] hst_addr,
    input  logic [DAT_W-1:0]    hst_wdat,
    output logic                hst_gnt,
    output logic                hst_rvld,
    output logic [DAT_W-1:0]    hst_rdat,
    output logic                mem_rdy
);

    localparam int unsigned DEPTH = 2 ** D_ADDR_W;
    localparam int unsigned CLR_W = D_ADDR_W + 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic [CLR_W-1:0]     clr_addr_q;
    logic [CLR_W-1:0]     clr_addr_d;
    logic                 clr_we_c;

    logic                 serve_c;
    logic                 core_rd_c;
    logic                 core_wr_c;
    logic                 host_acc_c;
    logic                 host_rd_c;
    logic                 host_wr_c;

    logic [DAT_W-1:0]     mem [DEPTH];

    // Clear-sweep sequencing; READY is absorbing until the next reset.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we_c   = 1'b0;
        if (state_q == CLEAR) begin
            clr_we_c   = ~rst_b;
            clr_addr_d = clr_addr_q + CLR_W'(1);
            if (clr_addr_q == CLR_LAST) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q    <= CLR_ON_RST ? CLEAR : READY;
            clr_addr_q <= '0;
            mem_rdy    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            mem_rdy    <= (state_d == READY);
        end
    end

    // Core always wins; the host is only taken on a core-idle cycle and never right after a grant.
    always_comb begin
        serve_c    = mem_rdy & ~rst_b;
        core_rd_c  = serve_c & ~dat_mem_en_b & ~dat_mem_rw;
        core_wr_c  = serve_c & ~dat_mem_en_b &  dat_mem_rw;
        host_acc_c = serve_c &  dat_mem_en_b & hst_req & ~hst_gnt;
        host_rd_c  = host_acc_c & ~hst_we;
        host_wr_c  = host_acc_c &  hst_we;
    end

    // Array is deliberately left out of reset; only the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_addr_q[D_ADDR_W-1:0]] <= '0;
        end else if (core_wr_c) begin
            mem[dat_mem_addr] <= o_mem_dat;
        end else if (host_wr_c) begin
            mem[hst_addr] <= hst_wdat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            hst_gnt <= 1'b0;
        end else begin
            hst_gnt <= host_acc_c;
        end
    end

    // Read pipes: the last stage is the output register and holds until the next return.
    if (RD_LAT == 1) begin : g_lat1
        always_ff @(posedge clk) begin
            if (rst_b) begin
                i_mem_dat <= '0;
                hst_rvld  <= 1'b0;
                hst_rdat  <= '0;
            end else begin
                if (core_rd_c) begin
                    i_mem_dat <= mem[dat_mem_addr];
                end
                hst_rvld <= host_rd_c;
                if (host_rd_c) begin
                    hst_rdat <= mem[hst_addr];
                end
            end
        end
    end else begin : g_lat2
        logic             core_v1;
        logic [DAT_W-1:0] core_d1;
        logic             host_v1;
        logic [DAT_W-1:0] host_d1;

        always_ff @(posedge clk) begin
            if (rst_b) begin
                core_v1   <= 1'b0;
                core_d1   <= '0;
                host_v1   <= 1'b0;
                host_d1   <= '0;
                i_mem_dat <= '0;
                hst_rvld  <= 1'b0;
                hst_rdat  <= '0;
            end else begin
                core_v1 <= core_rd_c;
                if (core_rd_c) begin
                    core_d1 <= mem[dat_mem_addr];
                end
                if (core_v1) begin
                    i_mem_dat <= core_d1;
                end
                host_v1 <= host_rd_c;
                if (host_rd_c) begin
                    host_d1 <= mem[hst_addr];
                end
                hst_rvld <= host_v1;
                if (host_v1) begin
                    hst_rdat <= host_d1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ldst_mem_resp.sv
// Directed bench: two responders (read latency 1 and 2) share one stimulus stream and
// are checked against a bench-side memory model through per-port expectation queues.
module tb_ldst_mem_resp;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] dat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          en_b;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
    logic          hst_req;
    logic          hst_we;
    logic [AW-1:0] hst_addr;
    logic [DW-1:0] hst_wdat;

    logic [DW-1:0] rdat1, hrdat1, rdat2, hrdat2;
    logic          gnt1, rvld1, rdy1, gnt2, rvld2, rdy2;

    logic [DW-1:0] model [DEPTH];
    exp_t          cq1[$];
    exp_t          cq2[$];
    exp_t          hq1[$];
    exp_t          hq2[$];
    exp_t          e_mon;
    logic          v_exp;
    logic [DW-1:0] last_core;

    int unsigned ncyc   = 0;
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    ldst_mem_resp #(.DAT_W(DW), .D_ADDR_W(AW), .RD_LAT(1), .CLR_ON_RST(1'b1)) u_dut_l1 (
        .clk(clk), .rst_b(rst_b), .dat_mem_en_b(en_b), .dat_mem_rw(rw),
        .dat_mem_addr(addr), .o_mem_dat(wdat), .i_mem_dat(rdat1),
        .hst_req(hst_req), .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdat(hst_wdat),
        .hst_gnt(gnt1), .hst_rvld(rvld1), .hst_rdat(hrdat1), .mem_rdy(rdy1)
    );

    ldst_mem_resp #(.DAT_W(DW), .D_ADDR_W(AW), .RD_LAT(2), .CLR_ON_RST(1'b1)) u_dut_l2 (
        .clk(clk), .rst_b(rst_b), .dat_mem_en_b(en_b), .dat_mem_rw(rw),
        .dat_mem_addr(addr), .o_mem_dat(wdat), .i_mem_dat(rdat2),
        .hst_req(hst_req), .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdat(hst_wdat),
        .hst_gnt(gnt2), .hst_rvld(rvld2), .hst_rdat(hrdat2), .mem_rdy(rdy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic core_idle();
        en_b = 1'b1;
    endtask

    task automatic core_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        en_b = 1'b0; rw = 1'b1; addr = a; wdat = d;
        model[a] = d;
        tick();
    endtask

    task automatic core_rd(input logic [AW-1:0] a);
        en_b = 1'b0; rw = 1'b0; addr = a;
        cq1.push_back('{due: ncyc + 1, dat: model[a]});
        cq2.push_back('{due: ncyc + 2, dat: model[a]});
        last_core = model[a];
        tick();
    endtask

    // Holds req until gnt; exp_wait is the number of edges the grant should take.
    task automatic host_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input int unsigned exp_wait);
        int unsigned waited;
        logic        got;
        waited = 0;
        got    = 1'b0;
        hst_req = 1'b1; hst_we = we; hst_addr = a; hst_wdat = d;
        while (!got && waited < 20) begin
            tick();
            waited = waited + 1;
            if (gnt1) got = 1'b1;
        end
        check("hst_gnt_wait", 32'(waited), 32'(exp_wait));
        if (got) begin
            check("hst_gnt_l2", 32'(gnt2), 32'(1));
            if (we) begin
                model[a] = d;
            end else begin
                hq1.push_back('{due: ncyc,     dat: model[a]});
                hq2.push_back('{due: ncyc + 1, dat: model[a]});
            end
        end
        hst_req = 1'b0;
    endtask

    // Output monitor, half a cycle after the active edge.
    always begin
        @(negedge clk);
        #1;
        while (cq1.size() > 0 && cq1[0].due <= ncyc) begin
            e_mon = cq1.pop_front();
            check("core_rd_l1", 32'(rdat1), 32'(e_mon.dat));
        end
        while (cq2.size() > 0 && cq2[0].due <= ncyc) begin
            e_mon = cq2.pop_front();
            check("core_rd_l2", 32'(rdat2), 32'(e_mon.dat));
        end
        v_exp = (hq1.size() > 0 && hq1[0].due <= ncyc);
        if (rvld1 || v_exp) begin
            check("hst_rvld_l1", 32'(rvld1), 32'(v_exp));
            if (v_exp) begin
                e_mon = hq1.pop_front();
                check("hst_rdat_l1", 32'(hrdat1), 32'(e_mon.dat));
            end
        end
        v_exp = (hq2.size() > 0 && hq2[0].due <= ncyc);
        if (rvld2 || v_exp) begin
            check("hst_rvld_l2", 32'(rvld2), 32'(v_exp));
            if (v_exp) begin
                e_mon = hq2.pop_front();
                check("hst_rdat_l2", 32'(hrdat2), 32'(e_mon.dat));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b1; en_b = 1'b1; rw = 1'b0; addr = '0; wdat = '0;
        hst_req = 1'b0; hst_we = 1'b0; hst_addr = '0; hst_wdat = '0;
        last_core = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset held for three edges
        repeat (3) tick();
        check("rst_rdy_l1", 32'(rdy1), 32'(0));
        check("rst_rdy_l2", 32'(rdy2), 32'(0));
        check("rst_gnt", 32'(gnt1), 32'(0));
        check("rst_rvld", 32'(rvld1), 32'(0));
        check("rst_imem_l1", 32'(rdat1), 32'(0));
        check("rst_imem_l2", 32'(rdat2), 32'(0));
        rst_b = 1'b0;

        // Clear sweep with ignored core and host traffic
        for (int i = 1; i <= 16; i++) begin
            if (i >= 8 && i <= 10) begin
                en_b = 1'b0; rw = 1'b1; addr = 4'd5; wdat = 8'hFF;
            end else if (i == 11) begin
                en_b = 1'b0; rw = 1'b0; addr = 4'd5;
            end else begin
                en_b = 1'b1;
            end
            hst_req = (i >= 2 && i <= 5); hst_we = 1'b1; hst_addr = 4'd7; hst_wdat = 8'h77;
            tick();
            check("sweep_rdy_l1", 32'(rdy1), 32'(i == 16));
            check("sweep_rdy_l2", 32'(rdy2), 32'(i == 16));
            if (i >= 2 && i <= 6) check("sweep_gnt", 32'(gnt1), 32'(0));
            if (i == 12) begin
                check("sweep_imem_hold_l1", 32'(rdat1), 32'(0));
                check("sweep_imem_hold_l2", 32'(rdat2), 32'(0));
            end
        end
        en_b = 1'b1; hst_req = 1'b0;

        // Whole array reads back zero
        for (int a = 0; a < DEPTH; a++) core_rd(AW'(a));

        // Core write/read patterns including boundary addresses
        core_wr(4'd3, 8'hA5);
        core_rd(4'd3);
        core_wr(4'd15, 8'h5A);
        core_wr(4'd0, 8'h01);
        core_rd(4'd15);
        core_rd(4'd0);
        core_rd(4'd3);
        core_idle();
        tick();

        // Host write stalled behind five core cycles
        hst_req = 1'b1; hst_we = 1'b1; hst_addr = 4'd9; hst_wdat = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            core_rd(4'd3);
            check("stall_gnt_l1", 32'(gnt1), 32'(0));
            check("stall_gnt_l2", 32'(gnt2), 32'(0));
        end
        core_idle();
        tick();
        check("stall_release_gnt_l1", 32'(gnt1), 32'(1));
        check("stall_release_gnt_l2", 32'(gnt2), 32'(1));
        model[9] = 8'h3C;
        hst_req = 1'b0;
        tick();
        check("gnt_pulse_l1", 32'(gnt1), 32'(0));
        core_rd(4'd9);
        core_idle();
        repeat (2) tick();

        // Host read with core idle; core data must stay put
        host_access(1'b0, 4'd9, 8'h00, 1);
        repeat (3) tick();
        check("imem_hold_l1", 32'(rdat1), 32'(last_core));
        check("imem_hold_l2", 32'(rdat2), 32'(last_core));
        check("hrdat_hold_l1", 32'(hrdat1), 32'(model[9]));
        check("hrdat_hold_l2", 32'(hrdat2), 32'(model[9]));

        // Back-to-back host requests: the second waits one extra edge
        host_access(1'b1, 4'd4, 8'h44, 1);
        host_access(1'b0, 4'd4, 8'h00, 2);
        host_access(1'b0, 4'd3, 8'h00, 2);
        core_rd(4'd4);
        core_idle();
        repeat (4) tick();

        // Reset mid-sweep restarts the clear from address 0
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        repeat (7) tick();
        rst_b = 1'b1;
        tick();
        check("rst2_rdy", 32'(rdy1), 32'(0));
        check("rst2_hrdat_l1", 32'(hrdat1), 32'(0));
        check("rst2_hrdat_l2", 32'(hrdat2), 32'(0));
        check("rst2_imem_l1", 32'(rdat1), 32'(0));
        rst_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("sweep2_rdy_l1", 32'(rdy1), 32'(i == 16));
            check("sweep2_rdy_l2", 32'(rdy2), 32'(i == 16));
        end
        core_rd(4'd3);
        core_rd(4'd9);
        core_rd(4'd4);
        core_idle();
        repeat (4) tick();

        check("core_q_l1_drained", 32'(cq1.size()), 32'(0));
        check("core_q_l2_drained", 32'(cq2.size()), 32'(0));
        check("host_q_l1_drained", 32'(hq1.size()), 32'(0));
        check("host_q_l2_drained", 32'(hq2.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
